alu_cmd_sequencer: RTL
======================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: queue capacity in entries; occupancy range 0..DEPTH.
REQ-002 Parameter TIMEOUT, default 15: cycles to wait for alu_sync before aborting; range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-007 cmd_type  input  1  0 = PUSH literal, 1 = COMPUTE.
REQ-008 cmd_data  input  8  literal for PUSH.
REQ-009 cmd_alu_op  input  3  ALU opcode for COMPUTE.
REQ-010 q_opcode  output  2  queue op: 00 NOP, 01 PUSH, 10 POP2_PUSH, 11 CLEAR.
REQ-011 q_back  output  8  value written to queue tail.
REQ-012 q_strobe  output  1  one-cycle pulse; queue executes q_opcode on it.
REQ-013 alu_opcode  output  3  opcode held stable from request to sync.
REQ-014 alu_req  output  1  one-cycle pulse starting an ALU operation.
REQ-015 alu_result  input  8  ALU result, valid when alu_sync=1.
REQ-016 alu_sync  input  1  one-cycle ALU completion pulse.
REQ-017 count  output  4  tracked queue occupancy.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 err  output  2  sticky: 00 none, 01 underflow, 10 overflow, 11 timeout.

Function
REQ-020 FSM states SHALL be IDLE, PUSH, ISSUE, WAIT_SYNC, WRITE.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-022 PUSH accepted at cycle N with count<DEPTH: q_opcode=01, q_back=cmd_data, q_strobe=1 at N+1; count+1; return to IDLE at N+2.
REQ-023 PUSH with count==DEPTH: no strobe, count unchanged, err=10, remain in IDLE.
REQ-024 COMPUTE with count<2: no strobe, no alu_req, err=01, remain in IDLE.
REQ-025 COMPUTE accepted at cycle N with count>=2: alu_opcode latched at N+1, alu_req=1 for exactly cycle N+1 (ISSUE), then WAIT_SYNC.
REQ-026 alu_sync in WAIT_SYNC: latch alu_result, go to WRITE; next cycle q_opcode=10, q_back=latched result, q_strobe=1, count-1, then IDLE.
REQ-027 alu_sync outside WAIT_SYNC SHALL be ignored.
REQ-028 q_opcode SHALL be 00 and q_back 0 whenever q_strobe=0.
REQ-029 err SHALL hold its value until rst or a CLEAR; a new error overwrites the old code.
REQ-030 COMPUTE with cmd_alu_op=7 SHALL be a CLEAR: q_opcode=11, q_strobe=1 at N+1, count=0, err=00, no alu_req.

Reset
REQ-031 With rst=1 on a rising edge: state=IDLE, count=0, err=00, q_strobe=0, alu_req=0, q_opcode=00, q_back=0, alu_opcode=0, busy=0; cmd_ready=1 the cycle after rst falls.
REQ-032 rst in WAIT_SYNC or WRITE SHALL abort the operation with no queue strobe issued.

Configuration
REQ-033 Macro ALU_SEQ_TIMEOUT_EN defined: 8-bit counter in WAIT_SYNC; after TIMEOUT cycles with no alu_sync, go to IDLE, err=11, count unchanged, no strobe.
REQ-034 Macro ALU_SEQ_TIMEOUT_EN undefined: no counter; WAIT_SYNC exits only on alu_sync or rst.

Verification
REQ-035 rst, then PUSH 1,2,3,4 -> four q_strobe pulses, opcode 01, q_back 1..4, count=4, err=00.
REQ-036 count=4, COMPUTE op=2, alu_sync with alu_result=0x07 three cycles after alu_req -> one POP2_PUSH strobe, q_back=0x07, count=3.
REQ-037 After rst, COMPUTE op=1 -> err=01, no strobe, no alu_req; DEPTH+1 PUSHes -> last rejected, err=10, count=8.
REQ-038 With ALU_SEQ_TIMEOUT_EN, TIMEOUT=15, no alu_sync -> IDLE after 15 WAIT_SYNC cycles, err=11, count unchanged; without macro, busy stays 1.
REQ-039 rst asserted in WAIT_SYNC, then alu_sync -> no strobe, count=0, cmd_ready=1 next cycle.
REQ-040 count=3, err=01, COMPUTE op=7 -> q_opcode=11 strobe, count=0, err=00.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts PUSH / COMPUTE commands, drives a result
// queue (PUSH, POP2_PUSH, CLEAR) and an external ALU (req/sync handshake),
// tracks queue occupancy and keeps a sticky error code.
// Optional feature: define ALU_SEQ_TIMEOUT_EN to abort a WAIT_SYNC that
// sees no alu_sync within TIMEOUT cycles (err=11, count unchanged).
module alu_cmd_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_type,
  input  logic [7:0] cmd_data,
  input  logic [2:0] cmd_alu_op,
  output logic [1:0] q_opcode,
  output logic [7:0] q_back,
  output logic       q_strobe,
  output logic [2:0] alu_opcode,
  output logic       alu_req,
  input  logic [7:0] alu_result,
  input  logic       alu_sync,
  output logic [3:0] count,
  output logic       busy,
  output logic [1:0] err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_ISSUE,
    S_WAIT_SYNC,
    S_WRITE
  } state_t;

  localparam logic [3:0] DEPTH_C  = 4'(DEPTH);
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP2  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_UNF  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [1:0] err_q, err_d;
  logic [2:0] alu_opcode_q, alu_opcode_d;
  // Set when the PUSH state is carrying a CLEAR rather than a literal push.
  logic       clr_q, clr_d;
  // Holds the literal to push, or the ALU result to write back.
  logic [7:0] data_q, data_d;
`ifdef ALU_SEQ_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q, tmo_d;
`endif

  assign count      = count_q;
  assign err        = err_q;
  assign alu_opcode = alu_opcode_q;

  // Next-state, register updates and decoded outputs of the command FSM.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    err_d        = err_q;
    alu_opcode_d = alu_opcode_q;
    clr_d        = clr_q;
    data_d       = data_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    cmd_ready    = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    q_strobe     = 1'b0;
    q_opcode     = OP_NOP;
    q_back       = 8'd0;
    alu_req      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!cmd_type) begin
            if (count_q < DEPTH_C) begin
              state_d = S_PUSH;
              clr_d   = 1'b0;
              data_d  = cmd_data;
            end else begin
              err_d = ERR_OVF;
            end
          end else if (cmd_alu_op == 3'd7) begin
            state_d = S_PUSH;
            clr_d   = 1'b1;
          end else if (count_q < 4'd2) begin
            err_d = ERR_UNF;
          end else begin
            state_d      = S_ISSUE;
            alu_opcode_d = cmd_alu_op;
          end
        end
      end
      S_PUSH: begin
        q_strobe = 1'b1;
        state_d  = S_IDLE;
        if (clr_q) begin
          q_opcode = OP_CLEAR;
          count_d  = 4'd0;
          err_d    = ERR_NONE;
        end else begin
          q_opcode = OP_PUSH;
          q_back   = data_q;
          count_d  = count_q + 4'd1;
        end
      end
      S_ISSUE: begin
        alu_req = 1'b1;
        state_d = S_WAIT_SYNC;
`ifdef ALU_SEQ_TIMEOUT_EN
        tmo_d   = 8'd0;
`endif
      end
      S_WAIT_SYNC: begin
        if (alu_sync) begin
          data_d  = alu_result;
          state_d = S_WRITE;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = ERR_TMO;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      S_WRITE: begin
        q_strobe = 1'b1;
        q_opcode = OP_POP2;
        q_back   = data_q;
        count_d  = count_q - 4'd1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= 4'd0;
      err_q        <= ERR_NONE;
      alu_opcode_q <= 3'd0;
      clr_q        <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      tmo_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      err_q        <= err_d;
      alu_opcode_q <= alu_opcode_d;
      clr_q        <= clr_d;
`ifdef ALU_SEQ_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  // Data holding register; never observed outside a strobe, so no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule
